// File: rtl/gray_ticket_pkg.sv
// Shared constants and Gray-code helper for the Gray-coded ticket arbiter.
// Ticket widths up to GRAY_MAX_W bits are supported by bin2gray.
package gray_ticket_pkg;

    localparam int DEFAULT_NUM_REQ       = 4;
    localparam int DEFAULT_COUNTER_WIDTH = 4;
    localparam int GRAY_MAX_W            = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_ticket_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i wins.
// A requester set in mask_i is never picked.
module gray_ticket_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   cand;

    assign eligible = req_i & ~mask_i;

    // Walk the indices in priority order starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!valid_o && eligible[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_ticket_arbiter.sv
// Round-robin ticket arbiter issuing Gray-coded tickets with a registered one-hot grant.
// Define GRAY_TICKET_LOCK_EN to add the lock input that pins eligibility to the last winner.
module gray_ticket_arbiter
    import gray_ticket_pkg::*;
#(
    parameter int NUM_REQ       = DEFAULT_NUM_REQ,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic                     hold,
`ifdef GRAY_TICKET_LOCK_EN
    input  logic                     lock,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     ticket_valid,
    output logic [COUNTER_WIDTH-1:0] ticket_gray,
    output logic                     wrap
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic                     valid_q, valid_d;
    logic [COUNTER_WIDTH-1:0] gray_q, gray_d;
    logic                     wrap_q, wrap_d;

    logic [NUM_REQ-1:0]       candidates;
    logic [NUM_REQ-1:0]       winner;
    logic [IDX_W-1:0]         winIdx;
    logic                     winValid;

`ifdef GRAY_TICKET_LOCK_EN
    logic [NUM_REQ-1:0]       lastGnt_q, lastGnt_d;

    assign candidates = lock ? (req & lastGnt_q) : req;
`else
    assign candidates = req;
`endif

    // The requester currently being granted is masked so a late req drop cannot double-grant.
    gray_ticket_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (candidates),
        .mask_i  (gnt_q),
        .ptr_i   (ptr_q),
        .gnt_o   (winner),
        .idx_o   (winIdx),
        .valid_o (winValid)
    );

    always_comb begin
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        valid_d   = 1'b0;
        gray_d    = gray_q;
        wrap_d    = 1'b0;
`ifdef GRAY_TICKET_LOCK_EN
        lastGnt_d = lastGnt_q;
`endif
        if (!hold && winValid) begin
            gnt_d   = winner;
            valid_d = 1'b1;
            gray_d  = COUNTER_WIDTH'(bin2gray(GRAY_MAX_W'(cnt_q)));
            wrap_d  = (cnt_q == '1);
            cnt_d   = cnt_q + 1'b1;
            ptr_d   = (winIdx == IDX_W'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
`ifdef GRAY_TICKET_LOCK_EN
            lastGnt_d = winner;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            gray_q    <= '0;
            wrap_q    <= 1'b0;
`ifdef GRAY_TICKET_LOCK_EN
            lastGnt_q <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            gray_q    <= gray_d;
            wrap_q    <= wrap_d;
`ifdef GRAY_TICKET_LOCK_EN
            lastGnt_q <= lastGnt_d;
`endif
        end
    end

    assign gnt          = gnt_q;
    assign ticket_valid = valid_q;
    assign ticket_gray  = gray_q;
    assign wrap         = wrap_q;

endmodule
